// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   rx_state_t        : receiver FSM state encoding
//   CLKS_PER_BIT_DEF  : default system clocks per serial bit
//   DATA_BITS_DEF     : default data bits per frame
//   half_bit()        : bit-timer value at which the start bit is sampled
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // The start bit is re-checked half a bit after the falling edge, so every
  // later sample lands near the centre of its bit cell.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Consumer-side bundle of the UART receiver.
//   read_ack      : consumer acknowledge, clears byte_valid
//   data_out      : last correctly framed byte
//   byte_valid    : data_out holds an unread byte
//   framing_error : one-cycle pulse on a low stop bit
//   overrun       : one-cycle pulse when a good byte is dropped
//   busy          : receiver is inside a frame
// Modports: master = receiver side, slave = consumer side.
interface uart_receiver_if import uart_pkg::*; #(
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic                 read_ack;
  logic [DATA_BITS-1:0] data_out;
  logic                 byte_valid;
  logic                 framing_error;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  read_ack,
    output data_out,
    output byte_valid,
    output framing_error,
    output overrun,
    output busy
  );

  modport slave (
    output read_ack,
    input  data_out,
    input  byte_valid,
    input  framing_error,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/uart_receiver_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk      : system clock
//   rst      : asynchronous active-low reset (both flops reset to idle-high)
//   async_in : raw serial line
//   sync_out : line value safe to use in the clk domain
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1-style framing, LSB first, idle-high line.
//   clk       : system clock, all state updates on its rising edge
//   rst       : asynchronous active-low reset
//   serial_in : asynchronous serial line
//   bus       : consumer bundle (read_ack in; data_out, byte_valid,
//               framing_error, overrun, busy out)
// Parameters: CLKS_PER_BIT (even, >= 4), DATA_BITS.
module uart_receiver import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serial_in,
  uart_receiver_if.master bus
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TIMER_W-1:0] BIT_END   = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] MID_START = TIMER_W'(half_bit(CLKS_PER_BIT));
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state;
  logic [TIMER_W-1:0]   timer;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (serial_in),
    .sync_out (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      rx_prev           <= 1'b1;
      timer             <= '0;
      idx               <= '0;
      shreg             <= '0;
      bus.data_out      <= '0;
      bus.byte_valid    <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.overrun       <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      // Edge detection needs the previous synchronized level; because it
      // requires a 1 -> 0 transition, a line held low after a break is
      // never mistaken for a new start bit.
      rx_prev           <= rx_s;
      bus.framing_error <= 1'b0;
      bus.overrun       <= 1'b0;

      // Acknowledge clears the flag; a byte completing in this same cycle
      // overrides it below because its assignment comes later.
      if (bus.read_ack) begin
        bus.byte_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state    <= START;
            timer    <= '0;
            bus.busy <= 1'b1;
          end
        end

        START: begin
          if (timer == MID_START) begin
            if (!rx_s) begin
              state <= DATA;
              timer <= '0;
              idx   <= '0;
            end else begin
              // Line already back high: a glitch, not a start bit.
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == BIT_END) begin
            timer      <= '0;
            shreg[idx] <= rx_s;
            if (idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (timer == BIT_END) begin
            timer    <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (rx_s) begin
              if (bus.byte_valid && !bus.read_ack) begin
                // Unread byte still pending: keep it, drop the new one.
                bus.overrun <= 1'b1;
              end else begin
                bus.data_out   <= shreg;
                bus.byte_valid <= 1'b1;
              end
            end else begin
              bus.framing_error <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (CLKS_PER_BIT=16, DATA_BITS=8).
// Frames are driven cycle by cycle; the expected receiver outcome is derived
// from the framing rules (good/bad stop bit, pending byte, acknowledge).
module tb_uart_receiver;

  localparam int C         = 16;
  localparam int D         = 8;
  localparam int H         = C / 2;
  localparam int LAT       = H + (D + 1) * C + 1;  // synchronized edge -> byte_valid
  localparam int SYNC_DLY  = 2;                    // line edge -> synchronized edge
  localparam int DONE      = LAT + SYNC_DLY;       // cycles from driving start bit
  localparam int FRAME_CYC = (D + 2) * C;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_data;
  logic       exp_valid;

  uart_receiver_if #(.DATA_BITS(D)) bus ();

  uart_receiver #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_ack();
    bus.read_ack = 1'b1;
    @(posedge clk); #1;
    bus.read_ack = 1'b0;
    exp_valid = 1'b0;
    check("ack_clears_valid", bus.byte_valid, 0);
  endtask

  // Drives one frame starting right after a clock edge. ack_done raises
  // read_ack so it is sampled in the byte-completion cycle. abort_at >= 0
  // asserts reset at that cycle of the frame instead of finishing it.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic ack_done, input int abort_at);
    logic [9:0] fr;
    int fe_n, ov_n;
    logic exp_fe, exp_ov;
    fr = {stop, b, 1'b0};
    fe_n = 0;
    ov_n = 0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    for (int cyc = 0; cyc < FRAME_CYC; cyc++) begin
      serial_in    = fr[cyc / C];
      bus.read_ack = ack_done && (cyc == DONE - 1);
      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_data_out", bus.data_out, 0);
        check("rst_byte_valid", bus.byte_valid, 0);
        check("rst_framing_error", bus.framing_error, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_busy", bus.busy, 0);
        exp_data     = 8'h00;
        exp_valid    = 1'b0;
        serial_in    = 1'b1;
        bus.read_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
      fe_n += int'(bus.framing_error);
      ov_n += int'(bus.overrun);
      if (cyc + 1 == DONE - 1) begin
        check("pre_done_valid", bus.byte_valid, exp_valid);
        check("pre_done_data", bus.data_out, exp_data);
        check("pre_done_busy", bus.busy, 1);
      end
      if (cyc + 1 == DONE) begin
        if (stop) begin
          if (exp_valid && !ack_done) exp_ov = 1'b1;
          else begin
            exp_data  = b;
            exp_valid = 1'b1;
          end
        end else begin
          exp_fe = 1'b1;
          if (ack_done) exp_valid = 1'b0;
        end
        check("done_valid", bus.byte_valid, exp_valid);
        check("done_data", bus.data_out, exp_data);
        check("done_framing_error", bus.framing_error, exp_fe);
        check("done_overrun", bus.overrun, exp_ov);
        check("done_busy", bus.busy, 0);
      end
    end
    serial_in    = 1'b1;
    bus.read_ack = 1'b0;
    check("frame_end_busy", bus.busy, 0);
    check("framing_error_pulses", fe_n, int'(exp_fe));
    check("overrun_pulses", ov_n, int'(exp_ov));
    repeat (4) @(posedge clk);
    #1;
    check("gap_busy", bus.busy, 0);
    check("gap_valid", bus.byte_valid, exp_valid);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    int         mode;
    int         fe_n;

    rst          = 1'b0;
    serial_in    = 1'b1;
    bus.read_ack = 1'b0;
    exp_data     = 8'h00;
    exp_valid    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_data_out", bus.data_out, 0);
    check("reset_byte_valid", bus.byte_valid, 0);
    check("reset_framing_error", bus.framing_error, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Basic good frame with exact completion timing.
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    do_ack();

    // Short low glitch on the idle line.
    fe_n = 0;
    for (int cyc = 0; cyc < 3 * C; cyc++) begin
      serial_in = (cyc < 4) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      fe_n += int'(bus.framing_error);
      if (cyc + 1 == 6) check("glitch_busy_start", bus.busy, 1);
    end
    check("glitch_busy_idle", bus.busy, 0);
    check("glitch_valid", bus.byte_valid, exp_valid);
    check("glitch_data", bus.data_out, exp_data);
    check("glitch_framing_error", fe_n, 0);

    // Low stop bit, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    send_frame(8'h88, 1'b1, 1'b0, -1);
    do_ack();

    // Overrun, then acknowledge in the completion cycle.
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    send_frame(8'h88, 1'b1, 1'b0, -1);
    send_frame(8'h88, 1'b1, 1'b1, -1);

    // Random frames: random data, mostly good stop bits, random acks.
    for (int n = 0; n < 8; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      mode  = int'($urandom_range(0, 2));
      if (mode == 1) do_ack();
      send_frame(rb, rstop, mode == 2, -1);
    end

    // Make sure a byte is pending, then reset in the middle of data bit 4.
    send_frame(8'hC3, 1'b1, 1'b1, -1);
    send_frame(8'hF0, 1'b1, 1'b0, 5 * C + H);
    repeat (3 * C) @(posedge clk);
    #1;
    check("post_rst_valid", bus.byte_valid, 0);
    check("post_rst_busy", bus.busy, 0);
    send_frame(8'h5A, 1'b1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
